// File: rtl/pkg_opengpu.sv
// Shared core types for the barrier front end.
// Warp geometry, barrier request bundle and per-warp wait states.
package pkg_opengpu;

   localparam int WARPS_PER_CORE   = 8;
   localparam int WARP_ID_WIDTH    = $clog2(WARPS_PER_CORE);
   localparam int BARRIER_ID_WIDTH = 4;

   typedef enum logic [1:0] {
      BW_IDLE    = 2'd0,
      BW_QUEUED  = 2'd1,
      BW_WAITING = 2'd2
   } barrier_wait_state_e;

   typedef struct packed {
      logic [WARP_ID_WIDTH-1:0]    warp_id;
      logic [BARRIER_ID_WIDTH-1:0] barrier_id;
      logic                        is_block;
      logic                        killed;
   } barrier_req_t;

endpackage

// File: rtl/barrier_req_fifo.sv
// Sync FIFO of barrier requests with occupancy count.
// Entries whose warp is killed get their killed bit set in place.
module barrier_req_fifo
   import pkg_opengpu::*;
#(
   parameter int DEPTH     = 4,
   parameter int NUM_WARPS = WARPS_PER_CORE
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  barrier_req_t           push_data_i,
   input  logic                   pop_i,
   input  logic [NUM_WARPS-1:0]   kill_i,
   output barrier_req_t           head_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   empty_o
);

   localparam int AW = $clog2(DEPTH);

   barrier_req_t    mem_q [DEPTH];
   logic [AW-1:0]   wptr_q;
   logic [AW-1:0]   rptr_q;
   logic [AW:0]     count_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_i) wptr_q <= wptr_q + 1'b1;
         if (pop_i)  rptr_q <= rptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage: mark killed entries, then write the pushed entry.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (kill_i[mem_q[i].warp_id]) mem_q[i].killed <= 1'b1;
      end
      if (push_i) mem_q[wptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rptr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/barrier_arrival_unit.sv
// Warp-side barrier front end: serializes SYNC/WSYNC arrivals,
// blocks warps until woken and flags deadlocks by timeout.
module barrier_arrival_unit
   import pkg_opengpu::*;
#(
   parameter int NUM_WARPS      = WARPS_PER_CORE,
   parameter int QUEUE_DEPTH    = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [WARP_ID_WIDTH-1:0]    req_warp_id,
   input  logic [BARRIER_ID_WIDTH-1:0] req_barrier_id,
   input  logic                        req_is_block,
   output logic                        barrier_arrive,
   output logic [WARP_ID_WIDTH-1:0]    arrive_warp_id,
   output logic [BARRIER_ID_WIDTH-1:0] barrier_id,
   output logic                        is_block_barrier,
   input  logic [NUM_WARPS-1:0]        warp_wake,
   input  logic [NUM_WARPS-1:0]        warp_kill,
   output logic [NUM_WARPS-1:0]        warp_blocked,
   output logic                        protocol_error,
   output logic                        timeout_error,
   output logic [WARP_ID_WIDTH-1:0]    timeout_warp_id,
   input  logic                        error_clear
);

   localparam int CW = $clog2(QUEUE_DEPTH) + 1;

   barrier_req_t             head;
   barrier_req_t             push_data;
   logic [CW-1:0]            count;
   logic                     empty;
   logic                     req_fire;
   logic                     req_idle;
   logic                     push;
   logic                     pop;
   logic                     head_live;
   logic [NUM_WARPS-1:0]     idle_vec;
   logic [NUM_WARPS-1:0]     hit_vec;
   logic [WARP_ID_WIDTH-1:0] first_hit;
   logic                     perr_q;
   logic                     terr_q;
   logic [WARP_ID_WIDTH-1:0] tid_q;

   assign req_ready = (count < CW'(QUEUE_DEPTH));
   assign req_fire  = req_valid & req_ready;
   assign req_idle  = idle_vec[req_warp_id];
   assign push      = req_fire & req_idle;

   assign push_data = '{
      warp_id:    req_warp_id,
      barrier_id: req_barrier_id,
      is_block:   req_is_block,
      killed:     warp_kill[req_warp_id]
   };

   // The controller has no backpressure: head pops every cycle.
   assign pop       = ~empty;
   assign head_live = pop & ~head.killed & ~warp_kill[head.warp_id];

   barrier_req_fifo #(
      .DEPTH     (QUEUE_DEPTH),
      .NUM_WARPS (NUM_WARPS)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (pop),
      .kill_i      (warp_kill),
      .head_o      (head),
      .count_o     (count),
      .empty_o     (empty)
   );

   assign barrier_arrive   = head_live;
   assign arrive_warp_id   = pop ? head.warp_id : '0;
   assign barrier_id       = pop ? head.barrier_id : '0;
   assign is_block_barrier = pop & head.is_block;

   for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
      barrier_wait_state_e st_q;
      barrier_wait_state_e st_d;
      logic [15:0]         cnt_q;
      logic [15:0]         cnt_d;
      logic                push_me;
      logic                arr_me;

      assign push_me = push & (req_warp_id == WARP_ID_WIDTH'(w));
      assign arr_me  = head_live & (head.warp_id == WARP_ID_WIDTH'(w));

      // Next state: kill, then wake, then enqueue, then arrival.
      always_comb begin
         st_d  = st_q;
         cnt_d = '0;
         if (warp_kill[w]) begin
            st_d = BW_IDLE;
         end else if (st_q != BW_IDLE && warp_wake[w]) begin
            st_d = BW_IDLE;
         end else if (st_q == BW_IDLE && push_me) begin
            st_d = BW_QUEUED;
         end else if (st_q == BW_QUEUED && arr_me) begin
            st_d = BW_WAITING;
         end
         if (!warp_kill[w] && st_q == BW_WAITING) begin
            cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
         end
      end

      // Per-warp wait state and deadlock timer.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            st_q  <= BW_IDLE;
            cnt_q <= '0;
         end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
         end
      end

      assign warp_blocked[w] = (st_q != BW_IDLE);
      assign idle_vec[w]     = (st_q == BW_IDLE);
      assign hit_vec[w]      = (cnt_q == 16'(TIMEOUT_CYCLES));
   end

   // Lowest-numbered warp among those timing out this cycle.
   always_comb begin
      first_hit = '0;
      for (int i = NUM_WARPS - 1; i >= 0; i--) begin
         if (hit_vec[i]) first_hit = WARP_ID_WIDTH'(i);
      end
   end

   // Error reporting: one-cycle protocol pulse, sticky timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perr_q <= 1'b0;
         terr_q <= 1'b0;
         tid_q  <= '0;
      end else begin
         perr_q <= req_fire & ~req_idle;
         if (error_clear) begin
            terr_q <= 1'b0;
            tid_q  <= '0;
         end else if (!terr_q && |hit_vec) begin
            terr_q <= 1'b1;
            tid_q  <= first_hit;
         end
      end
   end

   assign protocol_error  = perr_q;
   assign timeout_error   = terr_q;
   assign timeout_warp_id = tid_q;

endmodule
